// File: rtl/fp_pkg.sv
// fp_pkg: shared op encodings and default widths for the fp blocks
package fp_pkg;
  typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;
  localparam int EXP_W_DEF = 4;
  localparam int FRAC_W_DEF = 8;
endpackage

// File: rtl/fp_adder_pipe_if.sv
// fp_adder_pipe_if: operand/result handshake bundle for fp_adder_pipe
interface fp_adder_pipe_if
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
);
  logic in_valid, in_ready, op, sign1, sign2;
  logic [EXP_W-1:0] exp1, exp2;
  logic [FRAC_W-1:0] frac1, frac2;
  logic out_valid, out_ready, sign_out, ovf, unf;
  logic [EXP_W-1:0] exp_out;
  logic [FRAC_W-1:0] frac_out;
  modport master(
    output in_valid, op, sign1, sign2, exp1, exp2, frac1, frac2, out_ready,
    input in_ready, out_valid, sign_out, exp_out, frac_out, ovf, unf
  );
  modport slave(
    input in_valid, op, sign1, sign2, exp1, exp2, frac1, frac2, out_ready,
    output in_ready, out_valid, sign_out, exp_out, frac_out, ovf, unf
  );
endinterface

// File: rtl/fp_lzc.sv
// fp_lzc: combinational leading-zero count, all-zero input yields FRAC_W
module fp_lzc #(
  parameter int FRAC_W = 8
) (
  input  logic [FRAC_W-1:0]               a,
  output logic [$clog2(FRAC_W+1)-1:0]     lz
);
  localparam int LZ_W = $clog2(FRAC_W + 1);
  always_comb begin
    lz = LZ_W'(FRAC_W);
    for (int i = 0; i < FRAC_W; i++) lz = a[i] ? LZ_W'(FRAC_W - 1 - i) : lz;
  end
endmodule

// File: rtl/fp_adder_pipe.sv
// fp_adder_pipe: 3-stage sort/align, add, normalise floating-point adder with valid/ready flow
module fp_adder_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input logic clk,
  input logic reset,
  fp_adder_pipe_if.slave bus
);
  localparam int LZ_W = $clog2(FRAC_W + 1);
  logic adv, s2e, swap, sb_c, ss_c;
  logic [EXP_W-1:0] eb_c, es_c, d;
  logic [FRAC_W-1:0] fb_c, fs_c, al_c;
  logic v1, sb1, ss1, v2, sg2;
  logic [EXP_W-1:0] e1, e2;
  logic [FRAC_W-1:0] fb1, fs1;
  logic [FRAC_W:0] sum2;
  logic [LZ_W-1:0] lz;
  logic [EXP_W+LZ_W-1:0] ebx, lzx, ex;
  logic sg_c, ov_c, un_c;
  logic [EXP_W-1:0] eo_c;
  logic [FRAC_W-1:0] fo_c;
  assign adv = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  always_comb begin
    s2e = bus.sign2 ^ (op_e'(bus.op) == OP_SUB);
    swap = {bus.exp2, bus.frac2} > {bus.exp1, bus.frac1};
    sb_c = swap ? s2e : bus.sign1;
    ss_c = swap ? bus.sign1 : s2e;
    eb_c = swap ? bus.exp2 : bus.exp1;
    es_c = swap ? bus.exp1 : bus.exp2;
    fb_c = swap ? bus.frac2 : bus.frac1;
    fs_c = swap ? bus.frac1 : bus.frac2;
    d = eb_c - es_c;
    al_c = (32'(d) >= FRAC_W) ? '0 : fs_c >> d;
  end
  fp_lzc #(.FRAC_W(FRAC_W)) u_lzc (.a(sum2[FRAC_W-1:0]), .lz(lz));
  always_comb begin
    ebx = {{LZ_W{1'b0}}, e2};
    lzx = {{EXP_W{1'b0}}, lz};
    ex = ebx - lzx;
    sg_c = sg2;
    eo_c = ex[EXP_W-1:0];
    fo_c = sum2[FRAC_W-1:0] << lz;
    ov_c = 1'b0;
    un_c = 1'b0;
    if (sum2[FRAC_W]) begin
      ov_c = &e2;
      eo_c = ov_c ? '1 : e2 + 1'b1;
      fo_c = ov_c ? '1 : sum2[FRAC_W:1];
    end else if (sum2 == '0) begin
      {sg_c, eo_c, fo_c} = '0;
    end else if (lzx > ebx) begin
      {sg_c, eo_c, fo_c} = '0;
      un_c = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {v1, sb1, ss1, e1, fb1, fs1} <= '0;
      {v2, sg2, e2, sum2} <= '0;
      {bus.out_valid, bus.sign_out, bus.exp_out, bus.frac_out, bus.ovf, bus.unf} <= '0;
    end else if (adv) begin
      {v1, sb1, ss1, e1, fb1, fs1} <= {bus.in_valid, sb_c, ss_c, eb_c, fb_c, al_c};
      {v2, sg2, e2} <= {v1, sb1, e1};
      sum2 <= (sb1 == ss1) ? {1'b0, fb1} + {1'b0, fs1} : {1'b0, fb1} - {1'b0, fs1};
      {bus.out_valid, bus.sign_out, bus.exp_out, bus.frac_out, bus.ovf, bus.unf} <=
        {v2, sg_c, eo_c, fo_c, ov_c, un_c};
    end
  end
endmodule
